// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: two-bank buffer turning bit-reversed FFT frames into natural-order valid/ready output.
// Optional FFT_REORDER_OVF_EN adds ovf, a one-cycle pulse after each dropped input sample.
module fft_bitrev_reorder #(
  parameter int DW    = 12,
  parameter int LOG2N = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  output logic          in_ready,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  output logic          last_out,
`ifdef FFT_REORDER_OVF_EN
  output logic          ovf,
`endif
  input  logic          out_ready
);
  localparam int N = 2**LOG2N;
  logic [DW-1:0]    r_mem [2][N];
  logic [1:0]       r_full;
  logic             r_wsel, r_rsel, r_vld, r_last;
  logic [LOG2N-1:0] r_wcnt, r_rcnt, w_raddr;
  logic [DW-1:0]    r_dout;
  logic             w_wr, w_adv, w_rd;
  for (genvar i = 0; i < LOG2N; i++) begin : g_rev
    assign w_raddr[i] = r_rcnt[LOG2N-1-i];
  end
  assign in_ready  = !r_full[r_wsel];
  assign w_wr      = valid_in && in_ready;
  assign w_adv     = !r_vld || out_ready;
  assign w_rd      = w_adv && r_full[r_rsel];
  assign valid_out = r_vld;
  assign data_out  = r_dout;
  assign last_out  = r_last;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wsel][r_wcnt] <= data_in;
  // set and clear of r_full always hit different banks since wsel != rsel when both fire
  always_ff @(posedge clk)
    if (rst) begin
      r_full <= 2'b00;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_wcnt <= '0;
      r_rcnt <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_wr) begin
        r_wcnt <= r_wcnt + LOG2N'(1);
        if (&r_wcnt) begin
          r_full[r_wsel] <= 1'b1;
          r_wsel         <= !r_wsel;
        end
      end
      if (w_rd) begin
        r_rcnt <= r_rcnt + LOG2N'(1);
        r_dout <= r_mem[r_rsel][w_raddr];
        r_vld  <= 1'b1;
        r_last <= &r_rcnt;
        if (&r_rcnt) begin
          r_full[r_rsel] <= 1'b0;
          r_rsel         <= !r_rsel;
        end
      end else if (w_adv) begin
        r_vld  <= 1'b0;
        r_last <= 1'b0;
      end
    end
`ifdef FFT_REORDER_OVF_EN
  always_ff @(posedge clk)
    if (rst) ovf <= 1'b0;
    else ovf <= valid_in && !in_ready;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed and random checks of the reorder buffer against a frame-level queue model.
module tb_fft_bitrev_reorder;
  localparam int DW = 12;
  localparam int LOG2N = 3;
  localparam int N = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          in_ready, valid_out, last_out;
  logic [DW-1:0] data_out;
  logic          out_ready = 1'b0;
`ifdef FFT_REORDER_OVF_EN
  logic          ovf;
`endif
  int n_pass = 0, n_fail = 0, n_tot = 0;
  logic [DW-1:0] expq[$];
  logic          lq[$];
  logic [DW-1:0] fb[N];
  int            wpos = 0;

  fft_bitrev_reorder #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .in_ready(in_ready),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
`ifdef FFT_REORDER_OVF_EN
    .ovf(ovf),
`endif
    .out_ready(out_ready));

  always #5 clk = ~clk;

  function automatic int br(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (x & (1 << b)) r += 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic logic [DW-1:0] fval(input int idx);
    return DW'((idx / N) * N + br(idx % N));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive, remember pre-edge handshakes, then update the model and check outputs
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, output logic acc);
    logic deq, hold, pl;
    logic [DW-1:0] pd, nat[N];
    valid_in = v; data_in = d; out_ready = ordy;
    acc = v && in_ready; deq = valid_out && ordy; hold = valid_out && !ordy;
    pd = data_out; pl = last_out;
    @(posedge clk); #1;
    if (deq) begin
      chk("deq_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        chk("data", pd, expq.pop_front());
        chk("last", pl, lq.pop_front());
      end
    end
    if (hold) begin
      chk("hold_valid", valid_out, 1);
      chk("hold_data", data_out, pd);
      chk("hold_last", last_out, pl);
    end
    if (acc) begin
      fb[wpos] = d;
      wpos++;
      if (wpos == N) begin
        for (int p = 0; p < N; p++) nat[br(p)] = fb[p];
        for (int k = 0; k < N; k++) begin
          expq.push_back(nat[k]);
          lq.push_back(k == N - 1);
        end
        wpos = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete(); lq.delete(); wpos = 0;
  endtask

  task automatic drain();
    logic a;
    for (int t = 0; t < 64 && (expq.size() > 0 || valid_out); t++) cyc(1'b0, '0, 1'b1, a);
    chk("drain_empty", expq.size(), 0);
    chk("drain_valid", valid_out, 0);
  endtask

  initial begin
    logic a;
    int idx;
    do_reset();
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_last", last_out, 0);
`ifdef FFT_REORDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    // single frame
    for (int i = 0; i < N; i++) cyc(1'b1, fval(i), 1'b1, a);
    chk("t1_not_early", valid_out, 0);
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, '0, 1'b1, a);
      chk("t1_valid", valid_out, 1);
      chk("t1_value", data_out, k);
      chk("t1_last", last_out, k == N - 1);
    end
    cyc(1'b0, '0, 1'b1, a);
    chk("t1_end", valid_out, 0);
    // two back-to-back frames, no bubbles
    for (int i = 0; i < 3 * N; i++) begin
      if (i < 2 * N) chk("t2_in_ready", in_ready, 1);
      cyc(i < 2 * N, i < 2 * N ? fval(i) : '0, 1'b1, a);
      if (i == N - 1) chk("t2_not_early", valid_out, 0);
      if (i >= N) begin
        chk("t2_valid", valid_out, 1);
        chk("t2_value", data_out, i - N);
        chk("t2_last", last_out, (i - N) % N == N - 1);
      end
    end
    drain();
    // three frames with downstream stalled
    idx = 0;
    for (int t = 0; t < 40 && idx < 2 * N; t++) begin
      cyc(1'b1, fval(idx), 1'b0, a);
      if (a) idx++;
    end
    chk("t3_accepted", idx, 2 * N);
`ifdef FFT_REORDER_OVF_EN
    chk("t3_ovf_idle", ovf, 0);
`endif
    for (int t = 0; t < 3; t++) begin
      chk("t3_in_ready_low", in_ready, 0);
      cyc(1'b1, fval(idx), 1'b0, a);
      chk("t3_valid_held", valid_out, 1);
      chk("t3_data_held", data_out, 0);
`ifdef FFT_REORDER_OVF_EN
      chk("t3_ovf_pulse", ovf, 1);
`endif
    end
    cyc(1'b0, '0, 1'b0, a);
`ifdef FFT_REORDER_OVF_EN
    chk("t3_ovf_clear", ovf, 0);
`endif
    chk("t3_data_kept", data_out, 0);
    for (int t = 0; t < 60 && idx < 3 * N; t++) begin
      cyc(1'b1, fval(idx), 1'b1, a);
      if (a) idx++;
    end
    chk("t3_third_frame", idx, 3 * N);
    drain();
    // out_ready toggling
    for (int i = 0; i < N; i++) cyc(1'b1, fval(i), i[0], a);
    for (int t = 0; t < 40 && (expq.size() > 0 || valid_out); t++) cyc(1'b0, '0, t[0] == 1'b0, a);
    chk("t4_all_out", expq.size(), 0);
    drain();
    // randomized traffic
    for (int t = 0; t < 400; t++) cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, a);
    drain();
    // reset in the middle of a frame
    for (int i = 0; i < 5; i++) cyc(1'b1, fval(i), 1'b1, a);
    do_reset();
    chk("t5_valid", valid_out, 0);
    chk("t5_in_ready", in_ready, 1);
    for (int i = 0; i < N - 1; i++) cyc(1'b1, DW'(100 + i), 1'b1, a);
    cyc(1'b0, '0, 1'b1, a);
    chk("t5_no_stale", valid_out, 0);
    cyc(1'b1, DW'(100 + N - 1), 1'b1, a);
    chk("t5_queued", expq.size(), N);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side reorder buffer for the radix-2 SDF FFT pipeline.
- The delay-line stages emit results in bit-reversed index order; this block stores one frame and reads it out in natural order.
- Ping-pong (two-bank) buffering gives continuous throughput.
- Sits after the last butterfly stage and presents a valid/ready stream to downstream logic.

Parameters:
- DW, 12, sample width in bits; data is opaque, no arithmetic.
- LOG2N, 3, log2 of frame length; N = 2**LOG2N samples per frame.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- valid_in  input  1  data_in valid this cycle.
- data_in  input  DW  input sample, frame in bit-reversed order.
- in_ready  output  1  block can accept a sample this cycle.
- valid_out  output  1  data_out holds a valid sample.
- data_out  output  DW  output sample, natural order.
- last_out  output  1  high with the final (index N-1) sample of a frame.
- out_ready  input  1  downstream accepts data_out this cycle.

Behaviour:
- Storage: two banks of N x DW registers, bank[0..1]. Storage contents are not reset.
- Per-bank full flag: full[0..1].
- Write side:
  - State: wsel (bank select, 1 bit) and wcnt (LOG2N bits).
  - in_ready = !full[wsel], taken combinationally from registered state only.
  - A sample is accepted on an edge where valid_in && in_ready: bank[wsel][wcnt] <= data_in, then wcnt increments.
  - When wcnt == N-1 is accepted: full[wsel] <= 1, wsel toggles, wcnt wraps to 0.
  - If valid_in is high while in_ready is low, the sample is dropped; no state changes.
- Read side:
  - State: rsel (bank select) and rcnt (LOG2N bits).
  - Read address = bitrev(rcnt), i.e. bit i of rcnt maps to bit LOG2N-1-i of the address.
  - Output register advance condition: adv = !valid_out || out_ready.
  - When adv && full[rsel]:
    - data_out <= bank[rsel][bitrev(rcnt)]
    - valid_out <= 1
    - last_out <= (rcnt == N-1)
    - rcnt increments.
    - When rcnt == N-1 is read: full[rsel] <= 0, rsel toggles, rcnt wraps to 0.
  - When adv && !full[rsel]: valid_out <= 0, last_out <= 0; data_out holds its value.
  - While valid_out && !out_ready: data_out, valid_out and last_out hold stable.
- Latency:
  - Sample N-1 accepted at edge E sets full at E.
  - The first output, read address 0, is valid after edge E+1.
  - With out_ready held high, one sample per cycle follows.
- Simultaneous events:
  - Set and clear target different banks, because wsel != rsel whenever both are active.
  - A bank freed by the reader at edge E is writable from the cycle after E, since in_ready is registered-based. A 1-cycle write bubble is permitted only when both banks were full.
- Sustained throughput: N samples per N cycles with valid_in and out_ready continuously high.
- Reset values: wsel=0, rsel=0, wcnt=0, rcnt=0, full=2'b00, valid_out=0, data_out=0, last_out=0. in_ready is 1 out of reset.
- Reset mid-operation: partial and stored frames are discarded, and no output follows until a full new frame is written.

Optional Feature:
- Macro: FFT_REORDER_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0). ovf is a registered one-cycle pulse, asserted the cycle after any edge where valid_in && !in_ready (sample dropped).
- Not defined: the port is absent and dropped samples are silently ignored. All other behaviour is identical.

Test Plan (LOG2N=3, N=8):
- Single frame, input values 0,4,2,6,1,5,3,7 on 8 consecutive cycles, out_ready=1 -> data_out 0..7 on 8 consecutive cycles, starting 2 edges after the last input; last_out high only with value 7.
- Two back-to-back frames (second frame values +8), out_ready=1 -> 16 contiguous outputs 0..15 with no bubbles; in_ready stays 1; last_out high with values 7 and 15.
- Three frames input, out_ready=0 -> in_ready drops after 16 accepted samples; valid_out=1, data_out=0 held stable; raising out_ready drains 0..15, then the third frame is accepted.
- out_ready toggling 1,0,1,0 during readout -> every value appears exactly once in order 0..7; data_out is stable in all cycles where out_ready=0.
- rst asserted after 5 samples of frame 1 -> valid_out=0, in_ready=1 next cycle; a new full frame afterwards is output correctly with no stale samples.
- With FFT_REORDER_OVF_EN defined, out_ready=0, both banks full, valid_in=1 for 3 cycles -> ovf high 3 cycles, each one cycle later than its dropped sample; buffered data unchanged.
